// File: rtl/mem_arbiter.sv
// Round-robin arbiter serialising NUM_CORES read/write requests onto one
// single-port memory; each access is IDLE -> ACCESS -> DONE (3 cycles).
module mem_arbiter #(
  parameter int NUM_CORES  = 4,
  parameter int Data_width = 16,
  parameter int Addr_width = 12
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_CORES-1:0]            req,
  input  logic [NUM_CORES-1:0]            we,
  input  logic [NUM_CORES*Addr_width-1:0] addr,
  input  logic [NUM_CORES*Data_width-1:0] din,
  output logic [NUM_CORES-1:0]            ack,
  output logic [Data_width-1:0]           rdata,
  output logic                            busy,
  output logic                            mem_we,
  output logic [Addr_width-1:0]           mem_addr,
  output logic [Data_width-1:0]           mem_din,
  input  logic [Data_width-1:0]           mem_dout
);

  localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_CORES - 1);

  // Handshake: a core raises req with we/addr/din valid and holds them until
  // it sees its one-cycle ack pulse; it must drop req in the following cycle.
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                 state, state_nx;
  logic [IW-1:0]          rr_ptr;
  logic [IW-1:0]          winner;
  logic [IW-1:0]          pick;
  logic                   pick_valid;
  logic                   lat_we;
  logic [Addr_width-1:0]  lat_addr;
  logic [Data_width-1:0]  lat_din;
  logic [NUM_CORES-1:0]   ack_r;
  int                     idx;

  // Scan offsets from highest to lowest so the requester closest to rr_ptr wins.
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    idx        = 0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NUM_CORES;
      if (req[idx]) begin
        pick       = IW'(idx);
        pick_valid = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (pick_valid) state_nx = ACCESS;
      ACCESS:  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      winner   <= '0;
      lat_we   <= 1'b0;
      lat_addr <= '0;
      lat_din  <= '0;
      ack_r    <= '0;
    end else begin
      state <= state_nx;
      ack_r <= '0;
      if (state == IDLE && pick_valid) begin
        winner   <= pick;
        lat_we   <= we[pick];
        lat_addr <= addr[pick*Addr_width +: Addr_width];
        lat_din  <= din[pick*Data_width +: Data_width];
      end
      if (state == ACCESS) ack_r[winner] <= 1'b1;
      if (state == DONE) rr_ptr <= (winner == LAST) ? '0 : winner + 1'b1;
    end
  end

  // The latched address/data only change on acceptance, so they hold between accesses.
  assign mem_addr = lat_addr;
  assign mem_din  = lat_din;
  assign mem_we   = (state == ACCESS) & lat_we & ~rst;
  assign busy     = (state != IDLE);
  assign ack      = ack_r;
  assign rdata    = mem_dout;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_mem_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int AW = 12;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    we = '0;
  logic [N*AW-1:0] addr = '0;
  logic [N*DW-1:0] din = '0;
  logic [N-1:0]    ack;
  logic [DW-1:0]   rdata;
  logic            busy;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_din;
  logic [DW-1:0]   mem_dout;

  mem_arbiter #(.NUM_CORES(N), .Data_width(DW), .Addr_width(AW)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .din(din),
    .ack(ack), .rdata(rdata), .busy(busy), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- memory behind the arbiter ----------------
  logic [DW-1:0] ram [0:4095];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_din;
    mem_dout <= ram[mem_addr];
  end

  // ---------------- counters and check helper ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: no ack within cycle budget at %0t", name, $time);
  endtask

  // ---------------- reference model ----------------
  // Tracks one transaction: how many cycles since acceptance, who owns it,
  // and what was captured. The shadow memory holds what reads must return.
  logic [DW-1:0] model_mem [0:4095];
  int            m_phase = 0;
  int            m_ptr = 0;
  int            m_win = 0;
  logic          m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_din = '0;
  bit            started = 1'b0;
  int            exp_q[$];
  bit            found;
  int            cand;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_ptr = 0; m_win = 0;
      m_we = 1'b0; m_addr = '0; m_din = '0;
      started = 1'b1;
    end else if (m_phase == 0) begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        cand = (m_ptr + k) % N;
        if (!found && req[cand]) begin
          found   = 1'b1;
          m_win   = cand;
          m_we    = we[cand];
          m_addr  = addr[cand*AW +: AW];
          m_din   = din[cand*DW +: DW];
          m_phase = 1;
        end
      end
    end else if (m_phase == 1) begin
      if (m_we) model_mem[m_addr] = m_din;
      exp_q.push_back(m_win);
      m_phase = 2;
    end else begin
      m_ptr   = (m_win + 1) % N;
      m_phase = 0;
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [N-1:0] exp_ack;
  logic [N-1:0] ack_seen = '0;
  int           ack_log[$];
  int           ack_cyc[$];
  int           cyc = 0;
  int           we_cnt = 0;
  int           got;

  always @(negedge clk) begin
    cyc++;
    if (started) begin
      exp_ack = (m_phase == 2) ? (N'(1) << m_win) : '0;
      check("busy", busy, m_phase != 0);
      check("mem_we", mem_we, (m_phase == 1) && m_we && !rst);
      check("mem_addr", mem_addr, m_addr);
      check("mem_din", mem_din, m_din);
      check("ack", ack, exp_ack);
      if (m_phase == 2 && !m_we) check("rdata", rdata, model_mem[m_addr]);
      if (ack != '0) begin
        got = 0;
        for (int i = 0; i < N; i++) if (ack[i]) got = i;
        if (exp_q.size() == 0) check("ack_unexpected", ack, 0);
        else check("grant", got, exp_q.pop_front());
        ack_log.push_back(got);
        ack_cyc.push_back(cyc);
      end
      if (mem_we) we_cnt++;
      ack_seen |= ack;
    end
  end

  // ---------------- driver tasks ----------------
  logic [N-1:0] hold = '0;

  // Advance one cycle; cores that saw their ack drop req unless told to hold.
  task automatic step();
    @(posedge clk);
    #2;
    for (int i = 0; i < N; i++) if (ack_seen[i] && !hold[i]) req[i] = 1'b0;
    ack_seen = '0;
  endtask

  task automatic set_core(input int c, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    we[c] = w;
    addr[c*AW +: AW] = a;
    din[c*DW +: DW] = d;
    req[c] = 1'b1;
  endtask

  task automatic reset_dut();
    rst = 1'b1; req = '0; hold = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_ack(input int c, output logic [DW-1:0] rd, output bit ok);
    ok = 1'b0;
    rd = '0;
    for (int k = 0; k < 30 && !ok; k++) begin
      step();
      #1;
      if (ack[c]) begin
        rd = rdata;
        ok = 1'b1;
      end
    end
    if (ok) step();
  endtask

  // ---------------- directed scenarios ----------------
  logic [DW-1:0] rd;
  bit            ok;
  int            log0;
  int            wc0;

  initial begin
    for (int i = 0; i < 4096; i++) begin
      model_mem[i] = DW'(i * 7 + 1);
      ram[i] <= DW'(i * 7 + 1);
    end
    model_mem[3000] = 16'd3800; ram[3000] <= 16'd3800;
    for (int i = 0; i < 4; i++) begin
      model_mem[3800+i] = DW'(i + 1);
      ram[3800+i] <= DW'(i + 1);
    end
    model_mem[4004] = 16'd3;      ram[4004] <= 16'd3;
    model_mem[100]  = 16'hABCD;   ram[100]  <= 16'hABCD;

    // Reset state and a single read
    reset_dut();
    #1;
    check("rst_busy", busy, 0);
    check("rst_ack", ack, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_din", mem_din, 0);
    set_core(0, 1'b0, 12'd3000, 16'd0);
    step(); #1;
    check("t1_mem_addr", mem_addr, 3000);
    check("t1_busy_c2", busy, 1);
    check("t1_ack_c2", ack, 0);
    step(); #1;
    check("t1_ack_c3", ack, 4'b0001);
    check("t1_rdata", rdata, 3800);
    check("t1_busy_c3", busy, 1);
    step(); #1;
    check("t1_busy_c4", busy, 0);
    check("t1_ack_c4", ack, 0);
    step();

    // Write then read back through core 2
    reset_dut();
    wc0 = we_cnt;
    set_core(2, 1'b1, 12'd3900, 16'd77);
    step(); #1;
    check("t2_mem_we", mem_we, 1);
    check("t2_mem_addr", mem_addr, 3900);
    check("t2_mem_din", mem_din, 77);
    wait_ack(2, rd, ok);
    if (!ok) timeout_fail("t2_write_ack");
    check("t2_we_cycles", we_cnt - wc0, 1);
    set_core(2, 1'b0, 12'd3900, 16'd0);
    wait_ack(2, rd, ok);
    if (!ok) timeout_fail("t2_read_ack");
    check("t2_rdata", rd, 77);

    // Four simultaneous reads: served 0,1,2,3 at 3-cycle spacing
    reset_dut();
    log0 = ack_log.size();
    for (int i = 0; i < 4; i++) set_core(i, 1'b0, AW'(3800 + i), 16'd0);
    for (int i = 0; i < 4; i++) begin
      wait_ack(i, rd, ok);
      if (!ok) timeout_fail("t3_ack");
      check("t3_rdata", rd, i + 1);
    end
    if (ack_log.size() >= log0 + 4) begin
      for (int i = 0; i < 4; i++) check("t3_order", ack_log[log0+i], i);
      for (int i = 1; i < 4; i++) check("t3_spacing", ack_cyc[log0+i] - ack_cyc[log0+i-1], 3);
    end else timeout_fail("t3_ack_count");

    // Core 1 keeps requesting, core 3 asks once: 1,3,1,1
    reset_dut();
    log0 = ack_log.size();
    hold[1] = 1'b1;
    set_core(1, 1'b0, 12'd3801, 16'd0);
    set_core(3, 1'b0, 12'd3803, 16'd0);
    for (int k = 0; k < 40 && ack_log.size() < log0 + 4; k++) step();
    if (ack_log.size() >= log0 + 4) begin
      check("t4_grant0", ack_log[log0], 1);
      check("t4_grant1", ack_log[log0+1], 3);
      check("t4_grant2", ack_log[log0+2], 1);
      check("t4_grant3", ack_log[log0+3], 1);
    end else timeout_fail("t4_ack_count");
    hold = '0;
    req = '0;
    step(); step(); step(); step();

    // Reset during the ACCESS of a write cancels it
    reset_dut();
    log0 = ack_log.size();
    set_core(0, 1'b1, 12'd4004, 16'd9);
    step();
    rst = 1'b1;
    #1;
    check("t5_mem_we_cancel", mem_we, 0);
    step();
    rst = 1'b0;
    req = '0;
    #1;
    check("t5_busy", busy, 0);
    check("t5_ack", ack, 0);
    step(); step(); #1;
    check("t5_ram", ram[4004], 3);
    check("t5_no_ack", ack_log.size() - log0, 0);
    set_core(3, 1'b0, 12'd3803, 16'd0);
    set_core(0, 1'b0, 12'd3800, 16'd0);
    step(); step(); #1;
    check("t5_ptr_zero", ack, 4'b0001);
    wait_ack(3, rd, ok);
    if (!ok) timeout_fail("t5_core3_ack");
    check("t5_core3_rdata", rd, 4);

    // Inputs changed while busy do not affect the in-flight access
    reset_dut();
    set_core(0, 1'b0, 12'd100, 16'd0);
    step();
    set_core(0, 1'b1, 12'd200, 16'h5555);
    #1;
    check("t6_mem_addr", mem_addr, 100);
    check("t6_mem_we", mem_we, 0);
    step(); #1;
    check("t6_ack", ack, 4'b0001);
    check("t6_rdata", rdata, 16'hABCD);
    step(); step(); #1;
    check("t6_addr_hold", mem_addr, 100);
    check("t6_ram200", ram[200], 200 * 7 + 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

endmodule
